// File: rtl/floppy_multi_ctrl.sv
// Multi-drive floppy mechanism controller: shared Shugart host bus, per-drive
// head stepper sequencing, track tracking, spindle spin-up and index stretch.
//
// state    | meaning
// S_IDLE   | coils held, waiting for a step edge; recalibrates on track 0
// S_MOVE   | one cycle: advance/retreat coil phase, update track, load timer
// S_SETTLE | head settle timer running; new edges are dropped
module floppy_multi_ctrl #(
  parameter int NUM_DRIVES    = 4,
  parameter int MAX_TRACK     = 79,
  parameter int TRK_W         = 7,
  parameter int STEP_CYCLES   = 24000,
  parameter int SPINUP_CYCLES = 5000000,
  parameter int IDX_CYCLES    = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DRIVES-1:0]   drive_sel,
  input  logic [NUM_DRIVES-1:0]   motor_on,
  input  logic                    step,
  input  logic                    dir_sel,
  input  logic                    dens_sel,
  input  logic [NUM_DRIVES-1:0]   ind_sens,
  input  logic [NUM_DRIVES-1:0]   t00_sens,
  input  logic [NUM_DRIVES-1:0]   wpr_sens,
  input  logic [NUM_DRIVES-1:0]   dsk_sens,
  output logic [4*NUM_DRIVES-1:0] step_drv,
  output logic [NUM_DRIVES-1:0]   spin_en,
  output logic [NUM_DRIVES-1:0]   spin_ss,
  output logic                    track_0,
  output logic                    index,
  output logic                    wr_protect,
  output logic                    ready,
  output logic                    dsk_present,
  output logic [TRK_W-1:0]        trk_count,
  output logic [NUM_DRIVES-1:0]   step_ovr,
  output logic [NUM_DRIVES-1:0]   front_LED
);

  localparam int STW   = $clog2(STEP_CYCLES + 1);
  localparam int SPW   = $clog2(SPINUP_CYCLES + 1);
  localparam int IXW   = $clog2(IDX_CYCLES + 1);
  localparam int SEL_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE} step_state_t;

  step_state_t            st_q   [NUM_DRIVES];
  step_state_t            st_d   [NUM_DRIVES];
  logic [3:0]             ph_q   [NUM_DRIVES];
  logic [3:0]             ph_d   [NUM_DRIVES];
  logic [TRK_W-1:0]       trk_q  [NUM_DRIVES];
  logic [TRK_W-1:0]       trk_d  [NUM_DRIVES];
  logic [STW-1:0]         tmr_q  [NUM_DRIVES];
  logic [STW-1:0]         tmr_d  [NUM_DRIVES];
  logic [SPW-1:0]         spin_q [NUM_DRIVES];
  logic [SPW-1:0]         spin_d [NUM_DRIVES];
  logic [IXW-1:0]         idx_q  [NUM_DRIVES];
  logic [IXW-1:0]         idx_d  [NUM_DRIVES];
  logic [NUM_DRIVES-1:0]  mdir_q, mdir_d, ovr_d, step_hit, ready_i, ind_rise, led_d;
  logic [NUM_DRIVES-1:0]  ind_s1, ind_s2;
  logic [2:0]             step_sync;
  logic [1:0]             dir_sync;
  logic                   step_edge, dir_s, sel_valid;
  logic [SEL_W-1:0]       sel_idx;

  assign step_edge = step_sync[1] & ~step_sync[2];
  assign dir_s     = dir_sync[1];
  assign ind_rise  = ind_s1 & ~ind_s2;

  always_comb begin
    int n_low;
    n_low   = 0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (!drive_sel[i]) begin
        n_low   = n_low + 1;
        sel_idx = SEL_W'(i);
      end
    end
    sel_valid = (n_low == 1);
    step_hit  = '0;
    led_d     = '0;
    if (sel_valid) begin
      step_hit[sel_idx] = step_edge;
      led_d[sel_idx]    = motor_on[sel_idx];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DRIVES; i++) begin
      st_d[i]   = st_q[i];
      ph_d[i]   = ph_q[i];
      trk_d[i]  = trk_q[i];
      tmr_d[i]  = tmr_q[i];
      mdir_d[i] = mdir_q[i];
      ovr_d[i]  = step_ovr[i];
      case (st_q[i])
        S_IDLE: begin
          if (t00_sens[i]) trk_d[i] = '0;
          // step-out on track 0 and step-in at the last track are swallowed silently
          if (step_hit[i] && !(dir_s && t00_sens[i]) &&
              !(!dir_s && trk_q[i] == TRK_W'(MAX_TRACK))) begin
            st_d[i]   = S_MOVE;
            mdir_d[i] = dir_s;
          end
        end
        S_MOVE: begin
          if (mdir_q[i]) begin
            ph_d[i] = {ph_q[i][0], ph_q[i][3:1]};
            if (trk_q[i] != '0) trk_d[i] = trk_q[i] - TRK_W'(1);
          end else begin
            ph_d[i]  = {ph_q[i][2:0], ph_q[i][3]};
            trk_d[i] = trk_q[i] + TRK_W'(1);
          end
          tmr_d[i] = STW'(STEP_CYCLES);
          st_d[i]  = S_SETTLE;
          if (step_hit[i]) ovr_d[i] = 1'b1;
        end
        S_SETTLE: begin
          if (tmr_q[i] <= STW'(1)) begin
            tmr_d[i] = '0;
            st_d[i]  = S_IDLE;
          end else begin
            tmr_d[i] = tmr_q[i] - STW'(1);
          end
          if (step_hit[i]) ovr_d[i] = 1'b1;
        end
        default: st_d[i] = S_IDLE;
      endcase

      if (motor_on[i] && dsk_sens[i])
        spin_d[i] = (spin_q[i] == SPW'(SPINUP_CYCLES)) ? spin_q[i] : spin_q[i] + SPW'(1);
      else
        spin_d[i] = '0;
      ready_i[i] = (spin_q[i] == SPW'(SPINUP_CYCLES)) & motor_on[i] & dsk_sens[i];

      if (ind_rise[i])          idx_d[i] = IXW'(IDX_CYCLES);
      else if (idx_q[i] != '0)  idx_d[i] = idx_q[i] - IXW'(1);
      else                      idx_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DRIVES; i++) begin
        st_q[i]   <= S_IDLE;
        ph_q[i]   <= 4'b0001;
        trk_q[i]  <= '0;
        tmr_q[i]  <= '0;
        spin_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      mdir_q      <= '0;
      step_ovr    <= '0;
      step_sync   <= '0;
      dir_sync    <= '0;
      ind_s1      <= '0;
      ind_s2      <= '0;
      spin_en     <= '0;
      spin_ss     <= '0;
      front_LED   <= '0;
      track_0     <= 1'b0;
      index       <= 1'b0;
      wr_protect  <= 1'b0;
      ready       <= 1'b0;
      dsk_present <= 1'b0;
      trk_count   <= '0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      trk_q  <= trk_d;
      tmr_q  <= tmr_d;
      spin_q <= spin_d;
      idx_q  <= idx_d;
      mdir_q      <= mdir_d;
      step_ovr    <= ovr_d;
      step_sync   <= {step_sync[1:0], step};
      dir_sync    <= {dir_sync[0], dir_sel};
      ind_s1      <= ind_sens;
      ind_s2      <= ind_s1;
      spin_en     <= motor_on;
      spin_ss     <= {NUM_DRIVES{dens_sel}};
      front_LED   <= led_d;
      track_0     <= sel_valid & t00_sens[sel_idx];
      wr_protect  <= sel_valid & wpr_sens[sel_idx];
      dsk_present <= sel_valid & dsk_sens[sel_idx];
      ready       <= sel_valid & ready_i[sel_idx];
      index       <= sel_valid & (idx_q[sel_idx] != '0);
      // next-state track so the host sees the move on the same edge as the coils
      trk_count   <= sel_valid ? trk_d[sel_idx] : '0;
    end
  end

  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_coil
    assign step_drv[4*g +: 4] = ph_q[g];
  end

endmodule

// File: tb/tb_floppy_multi_ctrl.sv
// Self-checking bench for floppy_multi_ctrl: status-mux vector table, directed
// stepping/spin-up/index/reset sequences, and randomized stepping vs a model.
module tb_floppy_multi_ctrl;
  localparam int ND = 4, MT = 79, TW = 7, SC = 8, SU = 16, IC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] drive_sel, motor_on, ind_sens, t00_sens, wpr_sens, dsk_sens;
  logic          step, dir_sel, dens_sel;
  logic [4*ND-1:0] step_drv;
  logic [ND-1:0] spin_en, spin_ss, step_ovr, front_LED;
  logic          track_0, index, wr_protect, ready, dsk_present;
  logic [TW-1:0] trk_count;

  floppy_multi_ctrl #(
    .NUM_DRIVES(ND), .MAX_TRACK(MT), .TRK_W(TW),
    .STEP_CYCLES(SC), .SPINUP_CYCLES(SU), .IDX_CYCLES(IC)
  ) dut (
    .clk(clk), .rst(rst), .drive_sel(drive_sel), .motor_on(motor_on),
    .step(step), .dir_sel(dir_sel), .dens_sel(dens_sel),
    .ind_sens(ind_sens), .t00_sens(t00_sens), .wpr_sens(wpr_sens), .dsk_sens(dsk_sens),
    .step_drv(step_drv), .spin_en(spin_en), .spin_ss(spin_ss),
    .track_0(track_0), .index(index), .wr_protect(wr_protect), .ready(ready),
    .dsk_present(dsk_present), .trk_count(trk_count), .step_ovr(step_ovr),
    .front_LED(front_LED)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    logic [3:0] sel, motor, t00, wpr, dsk;
    logic       dens;
    logic [2:0] exp_st;
    logic [3:0] exp_led, exp_en, exp_ss;
  } vec_t;
  vec_t vecs [8];

  int   m_trk [ND];
  int   m_ph  [ND];
  int   m_acc [ND];
  logic [ND-1:0] m_ovr;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pulse_step(input logic d);
    dir_sel = d;
    step    = 1'b1;
    tick(2);
    step    = 1'b0;
  endtask

  function automatic logic [15:0] exp_drv();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'b0001 << m_ph[i];
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 3'b101, 4'b0001, 4'b0001, 4'b1111};
    vecs[2] = '{4'b1101, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 1'b1, 3'b010, 4'b0000, 4'b0001, 4'b1111};
    vecs[3] = '{4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 3'b101, 4'b0100, 4'b0100, 4'b0000};
    vecs[4] = '{4'b0111, 4'b1010, 4'b0000, 4'b1000, 4'b1000, 1'b0, 3'b011, 4'b1000, 4'b1010, 4'b0000};
    vecs[5] = '{4'b1100, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 3'b000, 4'b0000, 4'b1111, 4'b1111};
    vecs[6] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0, 3'b000, 4'b0000, 4'b1111, 4'b0000};
    vecs[7] = '{4'b1101, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1, 3'b111, 4'b0010, 4'b0010, 4'b1111};

    rst = 1'b1; drive_sel = 4'b1111; motor_on = '0; step = 1'b0; dir_sel = 1'b0;
    dens_sel = 1'b1; ind_sens = '0; t00_sens = '0; wpr_sens = '1; dsk_sens = '1;
    tick(2);
    check("rst_step_drv", 32'(step_drv), 32'h1111);
    check("rst_trk", 32'(trk_count), 32'd0);
    check("rst_misc", {16'd0, spin_en, spin_ss, step_ovr, front_LED}, 32'd0);
    check("rst_status", {27'd0, track_0, index, wr_protect, ready, dsk_present}, 32'd0);
    rst = 1'b0;
    wpr_sens = '0; dsk_sens = '0;
    tick(1);

    for (int v = 0; v < 8; v++) begin
      drive_sel = vecs[v].sel; motor_on = vecs[v].motor; t00_sens = vecs[v].t00;
      wpr_sens = vecs[v].wpr; dsk_sens = vecs[v].dsk; dens_sel = vecs[v].dens;
      tick(1);
      check($sformatf("vec%0d_status", v),
            {17'd0, track_0, wr_protect, dsk_present, front_LED, spin_en, spin_ss},
            {17'd0, vecs[v].exp_st, vecs[v].exp_led, vecs[v].exp_en, vecs[v].exp_ss});
    end
    motor_on = '0; t00_sens = '0; wpr_sens = '0; dsk_sens = '0;
    tick(4);

    // drive 2: three step-ins, first one with exact latency
    drive_sel = 4'b1011;
    tick(2);
    pulse_step(1'b0);
    tick(1);
    check("lat_before_drv", 32'(step_drv), 32'h1111);
    check("lat_before_trk", 32'(trk_count), 32'd0);
    tick(1);
    check("lat_move_drv", 32'(step_drv), 32'h1211);
    check("lat_move_trk", 32'(trk_count), 32'd1);
    tick(16);
    pulse_step(1'b0); tick(18);
    check("in2_drv", 32'(step_drv), 32'h1411);
    check("in2_trk", 32'(trk_count), 32'd2);
    pulse_step(1'b0); tick(18);
    check("in3_drv", 32'(step_drv), 32'h1811);
    check("in3_trk", 32'(trk_count), 32'd3);
    check("in3_ovr", 32'(step_ovr), 32'h0);

    // two edges 4 clocks apart: second is dropped
    pulse_step(1'b0); tick(2); pulse_step(1'b0); tick(20);
    check("ovr_drv", 32'(step_drv), 32'h1111);
    check("ovr_trk", 32'(trk_count), 32'd4);
    check("ovr_flag", 32'(step_ovr), 32'b0100);

    // drive 1: spacing of STEP_CYCLES+2 accepted, one less dropped
    drive_sel = 4'b1101;
    tick(2);
    pulse_step(1'b0); tick(8); pulse_step(1'b0); tick(20);
    check("gap10_trk", 32'(trk_count), 32'd2);
    check("gap10_ovr", 32'(step_ovr), 32'b0100);
    check("gap10_drv", 32'(step_drv), 32'h1141);
    pulse_step(1'b0); tick(7); pulse_step(1'b0); tick(20);
    check("gap9_trk", 32'(trk_count), 32'd3);
    check("gap9_ovr", 32'(step_ovr), 32'b0110);
    check("gap9_drv", 32'(step_drv), 32'h1181);

    // drive 0: step-out on track 0, then 80 step-ins saturating at MAX_TRACK
    drive_sel = 4'b1110; t00_sens = 4'b0001;
    tick(2);
    check("t00_status", 32'(track_0), 32'd1);
    pulse_step(1'b1); tick(20);
    check("t00_trk", 32'(trk_count), 32'd0);
    check("t00_drv", 32'(step_drv), 32'h1181);
    check("t00_ovr", 32'(step_ovr), 32'b0110);
    t00_sens = '0;
    tick(1);
    repeat (80) begin
      pulse_step(1'b0); tick(9);
    end
    check("max_trk", 32'(trk_count), 32'd79);
    check("max_drv", 32'(step_drv), 32'h1188);
    check("max_ovr", 32'(step_ovr), 32'b0110);
    pulse_step(1'b1); tick(12);
    check("out_trk", 32'(trk_count), 32'd78);
    check("out_drv", 32'(step_drv), 32'h1184);

    // drive 1 spin-up
    drive_sel = 4'b1101;
    tick(2);
    motor_on = 4'b0010; dsk_sens = 4'b0010;
    tick(16);
    check("spin_early", 32'(ready), 32'd0);
    tick(1);
    check("spin_ready", 32'(ready), 32'd1);
    check("spin_led", {24'd0, front_LED, spin_en}, {24'd0, 4'b0010, 4'b0010});
    tick(3);
    dsk_sens = '0;
    tick(1);
    check("spin_drop", {30'd0, ready, dsk_present}, 32'd0);
    motor_on = '0;
    tick(2);

    // two drives selected: step ignored, status zero
    drive_sel = 4'b1100; wpr_sens = 4'b0011; dsk_sens = 4'b0011;
    tick(2);
    pulse_step(1'b0); tick(20);
    check("multi_status", {27'd0, track_0, index, wr_protect, ready, dsk_present}, 32'd0);
    check("multi_trk", 32'(trk_count), 32'd0);
    check("multi_drv", 32'(step_drv), 32'h1184);
    check("multi_ovr", 32'(step_ovr), 32'b0110);
    wpr_sens = '0; dsk_sens = '0;

    // drive 3 index stretch
    drive_sel = 4'b0111;
    tick(2);
    ind_sens = 4'b1000;
    tick(1);
    ind_sens = '0;
    tick(1);
    check("idx_c2", 32'(index), 32'd0);
    for (int j = 3; j <= 7; j++) begin
      tick(1);
      check($sformatf("idx_c%0d", j), 32'(index), (j <= 6) ? 32'd1 : 32'd0);
    end

    // reset mid-settle
    motor_on = 4'b1000; dsk_sens = 4'b1000;
    pulse_step(1'b0); tick(4);
    rst = 1'b1;
    tick(1);
    check("rst2_step_drv", 32'(step_drv), 32'h1111);
    check("rst2_trk", 32'(trk_count), 32'd0);
    check("rst2_misc", {16'd0, spin_en, spin_ss, step_ovr, front_LED}, 32'd0);
    check("rst2_status", {27'd0, track_0, index, wr_protect, ready, dsk_present}, 32'd0);
    rst = 1'b0; motor_on = '0; dsk_sens = '0;
    pulse_step(1'b0); tick(2);
    check("post_rst_trk", 32'(trk_count), 32'd1);
    check("post_rst_drv", 32'(step_drv), 32'h2111);

    // randomized stepping against the model
    rst = 1'b1; drive_sel = 4'b1111; t00_sens = 4'b1111;
    tick(2);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < ND; i++) begin
      m_trk[i] = 0; m_ph[i] = 0; m_acc[i] = 0;
    end
    m_ovr = '0;
    for (int it = 0; it < 40; it++) begin
      int d, gap, det;
      logic dr;
      d   = $urandom_range(0, ND - 1);
      dr  = ($urandom_range(0, 9) < 4);
      gap = $urandom_range(6, 13);
      drive_sel = ~(4'b0001 << d);
      det = cyc + 3;
      if (det < m_acc[d]) m_ovr[d] = 1'b1;
      else if (dr && m_trk[d] == 0) ;
      else if (!dr && m_trk[d] == MT) ;
      else begin
        m_trk[d] = dr ? m_trk[d] - 1 : m_trk[d] + 1;
        m_ph[d]  = dr ? (m_ph[d] + 3) % 4 : (m_ph[d] + 1) % 4;
        m_acc[d] = det + 2 + SC;
      end
      pulse_step(dr);
      tick(2);
      t00_sens[d] = (m_trk[d] == 0);
      tick(gap - 4);
      check($sformatf("rnd%0d_trk", it), 32'(trk_count), 32'(m_trk[d]));
      check($sformatf("rnd%0d_drv", it), 32'(step_drv), 32'(exp_drv()));
      check($sformatf("rnd%0d_ovr", it), 32'(step_ovr), 32'(m_ovr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
